andor3_reg: RTL and testbench
=============================

# andor3_reg

Registered three-input AND/OR reduction block. It samples three equal-width operands `a`, `b`, `c` on each clock edge. It presents their bitwise 3-input AND on `y` and their bitwise 3-input OR on `z` one cycle later, with a valid flag alongside. It is a leaf gate-level utility used wherever a pipelined all-of/any-of combination of three signals is needed.

## Interface
- `WIDTH`, default 1: bit width of each operand and each result; legal range 1..64.
- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: synchronous, active-high reset; sampled on rising edge of `clk`.
- `in_valid` input 1: operands on `a`/`b`/`c` are meaningful this cycle.
- `a` input WIDTH: operand A.
- `b` input WIDTH: operand B.
- `c` input WIDTH: operand C.
- `y` output WIDTH: registered bitwise AND of the captured operands.
- `z` output WIDTH: registered bitwise OR of the captured operands.
- `out_valid` output 1: `y`/`z` hold a result captured from an `in_valid` cycle.

## Operation
- Per bit i: `y[i] = a[i] & b[i] & c[i]`; `z[i] = a[i] | b[i] | c[i]`. There is no cross-bit interaction.
- Inputs `a`, `b`, `c` are sampled every rising edge when `in_valid`=1.
  - `y` and `z` load the new results.
  - `out_valid` goes to 1.
- When `in_valid`=0 at an edge (and `rst`=0):
  - `y` and `z` hold their previous values.
  - `out_valid` goes to 0.
- Reset (`rst`=1 at an edge) has priority over `in_valid`:
  - `y` becomes all 0.
  - `z` becomes all 0.
  - `out_valid` becomes 0.
- Reset asserted mid-stream discards any pending result. The first result after reset is the one captured on the first edge with `rst`=0 and `in_valid`=1.
- Outputs are driven only from flops. There is no combinational path from any input to any output.
- Invariant: whenever `out_valid`=1, every bit satisfies `y[i]`=1 implies `z[i]`=1.
- X on an operand bit propagates only to that bit's results. No masking logic is required.

## Timing
- Latency is exactly 1 clock: inputs sampled at edge N appear on `y`/`z`/`out_valid` after edge N.
- Throughput is one result per cycle. There is no backpressure and no stall input.
- Back-to-back `in_valid` cycles each produce a result on consecutive cycles.
- Reset values: `y`=0, `z`=0, `out_valid`=0. They are valid from the first edge with `rst`=1.
- Before the first reset edge, output values are undefined. Benches must apply `rst` for at least 1 cycle.
- Simultaneous `rst`=1 and `in_valid`=1: reset wins and the operands are dropped.

## Test plan
- **Reset:** hold `rst`=1 for 2 cycles with `a`=`b`=`c`=1, `in_valid`=1 -> `y`=0, `z`=0, `out_valid`=0 throughout.
- **Exhaustive truth table** (WIDTH=1, `in_valid`=1): step {a,b,c} through 000..111, one per cycle. Each result appears one cycle later:
  - `y`=1 only for 111.
  - `z`=0 only for 000.
  - `out_valid`=1 on every result cycle.
- **Hold:** apply 111, then drop `in_valid` for 3 cycles while driving 000 -> `y`=1, `z`=1 held, `out_valid`=0 on those cycles.
- **Vector width** (WIDTH=8): a=8'hF0, b=8'hCC, c=8'hAA -> `y`=8'h80, `z`=8'hFE after 1 cycle. Then a=8'h00, b=8'h00, c=8'h01 -> `y`=8'h00, `z`=8'h01.
- **Reset mid-stream:** stream random operands, assert `rst` for 1 cycle with `in_valid`=1 -> next cycle `y`=0, `z`=0, `out_valid`=0. The following cycle resumes correct results with 1-cycle latency.
- **Random soak:** 1000 cycles of random `a`/`b`/`c`/`in_valid` at WIDTH=13, checked against a scoreboard. Also check the invariant `(y & ~z)`==0 whenever `out_valid`=1.

Source files
------------

// File: rtl/andor3_reg.sv
// rtl/andor3_reg.sv - registered bitwise 3-input AND/OR reduction with valid flag
module andor3_reg #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] z,
    output logic             out_valid
);

    logic [WIDTH-1:0] y_d, y_q;
    logic [WIDTH-1:0] z_d, z_q;
    logic             valid_d, valid_q;

    // Results hold when no new operands arrive; only the valid flag drops.
    always_comb begin
        y_d     = y_q;
        z_d     = z_q;
        valid_d = 1'b0;
        if (in_valid) begin
            y_d     = a & b & c;
            z_d     = a | b | c;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y_q     <= '0;
            z_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            y_q     <= y_d;
            z_q     <= z_d;
            valid_q <= valid_d;
        end
    end

    assign y         = y_q;
    assign z         = z_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_andor3_reg.sv
// tb/tb_andor3_reg.sv - directed and random checks of andor3_reg at widths 1, 8 and 13
module tb_andor3_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        iv1, iv8, iv13;
    logic        a1, b1, c1, y1, z1, v1;
    logic [7:0]  a8, b8, c8, y8, z8;
    logic        v8;
    logic [12:0] a13, b13, c13, y13, z13;
    logic        v13;

    logic [12:0] ey, ez;
    logic        ev;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    andor3_reg #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst(rst), .in_valid(iv1),
        .a(a1), .b(b1), .c(c1), .y(y1), .z(z1), .out_valid(v1)
    );

    andor3_reg #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst(rst), .in_valid(iv8),
        .a(a8), .b(b8), .c(c8), .y(y8), .z(z8), .out_valid(v8)
    );

    andor3_reg #(.WIDTH(13)) u_w13 (
        .clk(clk), .rst(rst), .in_valid(iv13),
        .a(a13), .b(b13), .c(c13), .y(y13), .z(z13), .out_valid(v13)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive13_random(input logic valid);
        a13  = 13'($urandom);
        b13  = 13'($urandom);
        c13  = 13'($urandom);
        iv13 = valid;
    endtask

    // Reference behaviour for the 13-bit instance, applied for the edge about to happen.
    task automatic model13();
        if (rst) begin
            ey = '0;
            ez = '0;
            ev = 1'b0;
        end else if (iv13) begin
            ey = a13 & b13 & c13;
            ez = a13 | b13 | c13;
            ev = 1'b1;
        end else begin
            ev = 1'b0;
        end
    endtask

    task automatic check13(input string tag);
        check({tag, "_y"}, 64'(y13), 64'(ey));
        check({tag, "_z"}, 64'(z13), 64'(ez));
        check({tag, "_v"}, 64'(v13), 64'(ev));
        if (v13)
            check({tag, "_inv"}, 64'(y13 & ~z13), 64'd0);
    endtask

    initial begin
        rst  = 1'b1;
        iv1  = 1'b1; a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
        iv8  = 1'b1; a8 = 8'hFF; b8 = 8'hFF; c8 = 8'hFF;
        iv13 = 1'b1; a13 = '1; b13 = '1; c13 = '1;
        ey = '0; ez = '0; ev = 1'b0;

        // Reset held for two cycles with all-ones operands and in_valid high
        for (int i = 0; i < 2; i++) begin
            tick();
            check("rst_y1", 64'(y1), 64'd0);
            check("rst_z1", 64'(z1), 64'd0);
            check("rst_v1", 64'(v1), 64'd0);
            check("rst_y8", 64'(y8), 64'd0);
            check("rst_z8", 64'(z8), 64'd0);
            check("rst_v8", 64'(v8), 64'd0);
            check("rst_y13", 64'(y13), 64'd0);
            check("rst_z13", 64'(z13), 64'd0);
            check("rst_v13", 64'(v13), 64'd0);
        end
        rst  = 1'b0;
        iv8  = 1'b0;
        iv13 = 1'b0;

        // Truth table at WIDTH=1
        for (int i = 0; i < 8; i++) begin
            {a1, b1, c1} = 3'(i);
            iv1 = 1'b1;
            tick();
            check($sformatf("tt%0d_y", i), 64'(y1), (i == 7) ? 64'd1 : 64'd0);
            check($sformatf("tt%0d_z", i), 64'(z1), (i != 0) ? 64'd1 : 64'd0);
            check($sformatf("tt%0d_v", i), 64'(v1), 64'd1);
        end

        // Hold: capture 111, then idle with 000 on the operands
        {a1, b1, c1} = 3'b111;
        iv1 = 1'b1;
        tick();
        check("hold_load_y", 64'(y1), 64'd1);
        check("hold_load_z", 64'(z1), 64'd1);
        {a1, b1, c1} = 3'b000;
        iv1 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("hold%0d_y", i), 64'(y1), 64'd1);
            check($sformatf("hold%0d_z", i), 64'(z1), 64'd1);
            check($sformatf("hold%0d_v", i), 64'(v1), 64'd0);
        end

        // Vector width at WIDTH=8
        a8 = 8'hF0; b8 = 8'hCC; c8 = 8'hAA; iv8 = 1'b1;
        tick();
        check("vec0_y", 64'(y8), 64'h80);
        check("vec0_z", 64'(z8), 64'hFE);
        check("vec0_v", 64'(v8), 64'd1);
        a8 = 8'h00; b8 = 8'h00; c8 = 8'h01;
        tick();
        check("vec1_y", 64'(y8), 64'h00);
        check("vec1_z", 64'(z8), 64'h01);
        check("vec1_v", 64'(v8), 64'd1);
        iv8 = 1'b0;

        // Reset mid-stream at WIDTH=13
        for (int i = 0; i < 5; i++) begin
            drive13_random(1'b1);
            model13();
            tick();
            check13("stream");
        end
        rst = 1'b1;
        drive13_random(1'b1);
        model13();
        tick();
        check("midrst_y", 64'(y13), 64'd0);
        check("midrst_z", 64'(z13), 64'd0);
        check("midrst_v", 64'(v13), 64'd0);
        rst = 1'b0;
        drive13_random(1'b1);
        model13();
        tick();
        check13("resume");

        // Random soak at WIDTH=13
        for (int i = 0; i < 1000; i++) begin
            drive13_random(($urandom_range(3) != 0) ? 1'b1 : 1'b0);
            model13();
            tick();
            check13("soak");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
